pac_man_mover: RTL and testbench

Commit stage for Pac-Man motion. Each game tick, `pac_man_mover` requests a candidate move from `pac_man_behavior` with a `start`/`done` handshake. It then checks the returned `next_block` against the maze wall map and commits the move into `curr_block`, which feeds back into `pac_man_behavior`. It also consumes pellets in the pellet memory, keeps the score, and flags level clear.

---
 rtl/pac_man_pkg.sv | 15 +
 rtl/pac_man_mover_if.sv | 22 ++
 rtl/pac_man_mover.sv | 109 ++++++++++
 tb/tb_pac_man_mover.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pac_man_pkg.sv
// Shared types for the Pac-Man motion blocks: block index, grid size, mover FSM states.
package pac_man_pkg;
  typedef logic [9:0] block_t;

  localparam int ROWS = 32;
  localparam int COLS = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RD   = 3'd3,
    CHK  = 3'd4
  } mover_state_e;
endpackage

// File: rtl/pac_man_mover_if.sv
// Move-request handshake with pac_man_behavior plus the shared wall ROM / pellet RAM port.
interface pac_man_mover_if;
  logic                  ready;
  logic                  done;
  pac_man_pkg::block_t   next_block;
  logic                  start;
  pac_man_pkg::block_t   mem_addr;
  logic                  wall_data;
  logic                  pellet_rdata;
  logic                  pellet_we;
  logic                  pellet_wdata;

  modport master (
    input  ready, done, next_block, wall_data, pellet_rdata,
    output start, mem_addr, pellet_we, pellet_wdata
  );

  modport slave (
    output ready, done, next_block, wall_data, pellet_rdata,
    input  start, mem_addr, pellet_we, pellet_wdata
  );
endinterface

// File: rtl/pac_man_mover.sv
// Commit stage for Pac-Man motion: requests a move per tick, checks it against the wall map,
// commits it, eats pellets, keeps score and flags level clear.
module pac_man_mover
  import pac_man_pkg::*;
#(
  parameter block_t START_BLOCK  = 10'd495,
  parameter int     PELLET_TOTAL = 240,
  parameter int     PELLET_PTS   = 10,
  parameter int     TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   move_tick,
  pac_man_mover_if.master        bus,
  output block_t                 curr_block,
  output logic                   pellet_eaten,
  output logic [15:0]            score,
  output logic                   level_clear,
  output logic                   timeout_err
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_REQ  = REQ;
  localparam logic [2:0] ST_WAIT = WAIT;
  localparam logic [2:0] ST_RD   = RD;
  localparam logic [2:0] ST_CHK  = CHK;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic          tick_pend;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   remaining;
  logic          go;
  logic          commit;
  logic [16:0]   score_sum;

  assign go        = tick_pend && bus.ready && !level_clear;
  assign commit    = !bus.wall_data && (bus.mem_addr != curr_block);
  assign score_sum = {1'b0, score} + 17'(PELLET_PTS);

  // start is decoded from state so it can never outlive the REQ cycle
  assign bus.start        = (state == ST_REQ);
  assign bus.pellet_wdata = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      tick_pend     <= 1'b0;
      wait_cnt      <= '0;
      curr_block    <= START_BLOCK;
      bus.mem_addr  <= START_BLOCK;
      bus.pellet_we <= 1'b0;
      pellet_eaten  <= 1'b0;
      score         <= '0;
      remaining     <= 16'(PELLET_TOTAL);
      level_clear   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      bus.pellet_we <= 1'b0;
      pellet_eaten  <= 1'b0;
      timeout_err   <= 1'b0;

      // one-deep tick latch: extra ticks while pending are dropped
      if (state == ST_IDLE && go)
        tick_pend <= 1'b0;
      else if (move_tick)
        tick_pend <= 1'b1;

      case (state)
        ST_IDLE: if (go) state <= ST_REQ;
        ST_REQ: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.done) begin
            bus.mem_addr <= bus.next_block;
            state        <= ST_RD;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RD: state <= ST_CHK;
        ST_CHK: begin
          if (commit) begin
            curr_block <= bus.mem_addr;
            // mem_addr is left alone so the clear lands on the eaten block next edge
            if (bus.pellet_rdata) begin
              bus.pellet_we <= 1'b1;
              pellet_eaten  <= 1'b1;
              score         <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
              if (remaining != 16'd0) begin
                remaining <= remaining - 16'd1;
                if (remaining == 16'd1) level_clear <= 1'b1;
              end
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pac_man_mover.sv
// Bench for pac_man_mover: directed handshake/timeout/reset steps, random moves against a
// maze model, and a second instance driven to score saturation and level clear.
module tb_pac_man_mover;
  import pac_man_pkg::*;

  localparam int SAT_TOTAL = 6555;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick, srst, stick;
  block_t curr, s_curr;
  logic eaten, lvl, to_err, s_eaten, s_lvl, s_to;
  logic [15:0] score, s_score;

  pac_man_mover_if bus ();
  pac_man_mover_if sbus ();

  pac_man_mover dut (
    .clk(clk), .reset(rst), .move_tick(tick), .bus(bus), .curr_block(curr),
    .pellet_eaten(eaten), .score(score), .level_clear(lvl), .timeout_err(to_err)
  );

  pac_man_mover #(.PELLET_TOTAL(SAT_TOTAL)) dut_sat (
    .clk(clk), .reset(srst), .move_tick(stick), .bus(sbus), .curr_block(s_curr),
    .pellet_eaten(s_eaten), .score(s_score), .level_clear(s_lvl), .timeout_err(s_to)
  );

  // memories seen by the main instance
  logic wall_mem [1024];
  logic pel_mem  [1024];
  always @(posedge clk) begin
    bus.wall_data    <= wall_mem[bus.mem_addr];
    bus.pellet_rdata <= pel_mem[bus.mem_addr];
    if (bus.pellet_we) pel_mem[bus.mem_addr] <= bus.pellet_wdata;
  end

  // saturation instance: open maze, pellet everywhere, bounce between two blocks
  always @(posedge clk) begin
    sbus.wall_data    <= 1'b0;
    sbus.pellet_rdata <= 1'b1;
  end
  assign sbus.next_block = (s_curr == 10'd500) ? 10'd501 : 10'd500;

  int start_cnt = 0, to_cnt = 0, we_cnt = 0, s_start_cnt = 0;
  block_t last_we_addr;
  always @(negedge clk) begin
    if (bus.start) start_cnt++;
    if (to_err) to_cnt++;
    if (bus.pellet_we) begin we_cnt++; last_we_addr = bus.mem_addr; end
    if (sbus.start) s_start_cnt++;
  end

  // reference model of the maze and game state
  logic   m_wall [1024];
  logic   m_pel  [1024];
  block_t m_cur;
  int     m_score, m_rem;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic model_reset();
    m_cur = 10'd495; m_score = 0; m_rem = 240;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_curr"}, 32'(curr), 32'd495);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd495);
    chk({tag, "_start"}, 32'(bus.start), 32'd0);
    chk({tag, "_we"}, 32'(bus.pellet_we), 32'd0);
    chk({tag, "_eaten"}, 32'(eaten), 32'd0);
    chk({tag, "_lvl"}, 32'(lvl), 32'd0);
    chk({tag, "_to"}, 32'(to_err), 32'd0);
  endtask

  task automatic request(output int lat);
    int s0;
    s0 = start_cnt; tick = 1'b1; cyc(); tick = 1'b0; lat = 1;
    while (start_cnt == s0 && lat < 40) begin cyc(); lat++; end
  endtask

  task automatic respond(input block_t nb);
    cyc(); bus.done = 1'b1; bus.next_block = nb;
    cyc(); bus.done = 1'b0;
    cyc(); cyc();
  endtask

  // called two edges after done was taken: commit results must be visible now
  task automatic check_move(input block_t nb);
    logic mv, eat;
    mv  = !m_wall[nb] && (nb != m_cur);
    eat = mv && m_pel[nb];
    if (mv) m_cur = nb;
    if (eat) begin
      m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      m_pel[nb] = 1'b0;
      if (m_rem > 0) m_rem--;
    end
    chk("curr_block", 32'(curr), 32'(m_cur));
    chk("score", 32'(score), 32'(m_score));
    chk("pellet_eaten", 32'(eaten), 32'(eat));
    chk("pellet_we", 32'(bus.pellet_we), 32'(eat));
    if (eat) chk("we_addr", 32'(bus.mem_addr), 32'(nb));
    chk("level_clear", 32'(lvl), 32'(m_rem == 0));
  endtask

  task automatic do_move(input block_t nb);
    int lat, s0, w0;
    s0 = start_cnt; w0 = we_cnt;
    request(lat);
    chk("start_latency", 32'(lat), 32'd2);
    respond(nb);
    check_move(nb);
    cyc();
    chk("start_pulses", 32'(start_cnt - s0), 32'd1);
    chk("we_pulses", 32'(we_cnt - w0), 32'(!m_pel[nb] && (w0 != we_cnt) ? 1 : 0));
  endtask

  initial begin
    int lat, n, s0, t0, scnt, exp_sc;
    block_t nb, tgt;

    rst = 1'b1; srst = 1'b1; tick = 1'b0; stick = 1'b1;
    bus.ready = 1'b1; bus.done = 1'b0; bus.next_block = '0;
    sbus.ready = 1'b1; sbus.done = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      wall_mem[i] = ($urandom_range(0, 3) == 0);
      pel_mem[i]  = 1'($urandom_range(0, 1));
    end
    wall_mem[463] = 1'b1; wall_mem[495] = 1'b0;
    wall_mem[496] = 1'b0; pel_mem[496] = 1'b1;
    for (int i = 0; i < 1024; i++) begin m_wall[i] = wall_mem[i]; m_pel[i] = pel_mem[i]; end
    model_reset();

    cyc(); cyc(); cyc();
    rst = 1'b0; cyc();
    chk_reset_outputs("reset");

    do_move(10'd463);
    do_move(10'd495);
    do_move(10'd496);
    chk("pellet_cleared", 32'(pel_mem[496]), 32'd0);
    chk("we_addr_496", 32'(last_we_addr), 32'd496);

    // timeout: withhold done, then a late done must be ignored
    t0 = to_cnt; s0 = start_cnt;
    request(lat);
    n = 0;
    while (to_cnt == t0 && n < 200) begin cyc(); n++; end
    chk("timeout_latency", 32'(n), 32'd65);
    bus.done = 1'b1; bus.next_block = 10'd497;
    cyc(); cyc(); cyc();
    bus.done = 1'b0; cyc(); cyc();
    chk("timeout_pulses", 32'(to_cnt - t0), 32'd1);
    chk("late_done_curr", 32'(curr), 32'(m_cur));
    chk("late_done_start", 32'(start_cnt - s0), 32'd1);

    // three ticks while busy: exactly one more move
    s0 = start_cnt;
    nb = m_cur + 10'd32;
    request(lat);
    tick = 1'b1; cyc();
    bus.done = 1'b1; bus.next_block = nb; cyc();
    bus.done = 1'b0; cyc();
    tick = 1'b0; cyc();
    check_move(nb);
    n = 0;
    while (start_cnt == s0 + 1 && n < 40) begin cyc(); n++; end
    chk("queued_tick_wait", 32'(n < 40), 32'd1);
    nb = m_cur - 10'd1;
    respond(nb);
    check_move(nb);
    for (int i = 0; i < 20; i++) cyc();
    chk("busy_ticks_starts", 32'(start_cnt - s0), 32'd2);

    // random moves against the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: nb = m_cur + 10'd1;
        1: nb = m_cur - 10'd1;
        2: nb = m_cur + 10'd32;
        3: nb = m_cur - 10'd32;
        4: nb = m_cur;
        default: nb = 10'($urandom);
      endcase
      do_move(nb);
    end

    // reset while the move is in RD: commit and pellet write are cancelled
    tgt = m_cur + 10'd1;
    wall_mem[tgt] = 1'b0; pel_mem[tgt] = 1'b1;
    request(lat);
    cyc(); bus.done = 1'b1; bus.next_block = tgt;
    cyc(); bus.done = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    chk_reset_outputs("rst_in_rd");
    cyc(); cyc();
    chk("rst_rd_pellet_kept", 32'(pel_mem[tgt]), 32'd1);
    chk("rst_rd_no_we", 32'(bus.pellet_we), 32'd0);
    model_reset();

    // saturation / level clear instance
    srst = 1'b0;
    scnt = 0; n = 0;
    while (scnt < SAT_TOTAL && n < 45000) begin
      cyc(); n++;
      if (s_eaten) begin
        scnt++;
        exp_sc = (scnt * 10 > 65535) ? 65535 : scnt * 10;
        chk("sat_score", 32'(s_score), 32'(exp_sc));
        chk("sat_level", 32'(s_lvl), 32'(scnt == SAT_TOTAL));
      end
    end
    chk("sat_pellets", 32'(scnt), 32'(SAT_TOTAL));
    s0 = s_start_cnt;
    for (int i = 0; i < 30; i++) cyc();
    chk("cleared_no_start", 32'(s_start_cnt - s0), 32'd0);
    chk("cleared_sticky", 32'(s_lvl), 32'd1);
    chk("sat_final_score", 32'(s_score), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
